// File: rtl/fft_frame_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : fft_frame_ctrl
//  Description : Per-frame sequencer for the microphone-array FFT path.
//                Launches the FFT on a full sample frame, launches the peak
//                detector, reads the peak bin from every channel RAM and
//                publishes the result together with status flags.
//  Revision    : 1.0 - initial release
// ============================================================================
module fft_frame_ctrl #(
    parameter int NCH = 4,
    parameter int AW  = 10,
    parameter int DW  = 28,
    parameter int TMO = 8192
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   frame_full,
    output logic                   fft_start,
    input  logic                   fft_done,
    output logic                   det_start,
    input  logic                   det_done,
    input  logic [AW-1:0]          det_bin,
    input  logic [AW-1:0]          det_addr,
    output logic [AW-1:0]          ram_addr,
    output logic [$clog2(NCH)-1:0] ram_sel,
    input  logic [DW-1:0]          ram_q,
    output logic [AW-1:0]          res_bin,
    output logic [NCH*DW-1:0]      res_data,
    output logic                   res_valid,
    output logic                   busy,
    output logic                   overrun,
    output logic                   timeout,
    output logic [15:0]            frame_cnt
);

    // NCH is expected to be at least 2 so the select port has a real width.
    localparam int              c_SW        = $clog2(NCH);
    localparam int              c_TW        = (TMO > 2) ? $clog2(TMO) : 1;
    localparam logic [c_TW-1:0] c_TMO_LAST  = c_TW'(TMO - 1);
    localparam logic [c_SW-1:0] c_LAST_CH   = c_SW'(NCH - 1);
    // RAM data is usable on the third cycle after the address is presented.
    localparam logic [1:0]      c_CAP_PHASE = 2'd2;

    localparam logic [2:0] c_IDLE   = 3'd0;
    localparam logic [2:0] c_FFT    = 3'd1;
    localparam logic [2:0] c_DETECT = 3'd2;
    localparam logic [2:0] c_READ   = 3'd3;
    localparam logic [2:0] c_DONE   = 3'd4;

    logic [2:0]                 r_state;
    logic [c_TW-1:0]            r_tmo_cnt;
    logic [AW-1:0]              r_bin;
    logic [c_SW-1:0]            r_ch;
    logic [1:0]                 r_phase;
    // Staging slots keep partial READ captures away from res_data.
    logic [NCH-1:0][DW-1:0]     r_slot;

    assign busy = (r_state != c_IDLE);

    // Read-port mux: detector owns the address in DETECT, the sequencer in READ,
    // otherwise the port rests on the last published bin.
    always_comb begin
        ram_addr = res_bin;
        ram_sel  = '0;
        case (r_state)
            c_DETECT: ram_addr = det_addr;
            c_READ: begin
                ram_addr = r_bin;
                ram_sel  = r_ch;
            end
            default: begin
                ram_addr = res_bin;
                ram_sel  = '0;
            end
        endcase
    end

    // Frame sequencer with registered pulses, sticky flags and result registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= c_IDLE;
            r_tmo_cnt <= '0;
            r_bin     <= '0;
            r_ch      <= '0;
            r_phase   <= '0;
            r_slot    <= '0;
            fft_start <= 1'b0;
            det_start <= 1'b0;
            res_valid <= 1'b0;
            overrun   <= 1'b0;
            timeout   <= 1'b0;
            frame_cnt <= '0;
            res_bin   <= '0;
            res_data  <= '0;
        end else begin
            fft_start <= 1'b0;
            det_start <= 1'b0;
            res_valid <= 1'b0;

            // A frame offered while a sequence is in flight is dropped.
            if (frame_full && (r_state != c_IDLE)) begin
                overrun <= 1'b1;
            end

            case (r_state)
                c_IDLE: begin
                    if (frame_full) begin
                        fft_start <= 1'b1;
                        r_tmo_cnt <= '0;
                        r_state   <= c_FFT;
                    end
                end
                c_FFT: begin
                    // Completion takes priority over the expiring timer.
                    if (fft_done) begin
                        det_start <= 1'b1;
                        r_state   <= c_DETECT;
                    end else if (r_tmo_cnt == c_TMO_LAST) begin
                        timeout <= 1'b1;
                        r_state <= c_IDLE;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + c_TW'(1);
                    end
                end
                c_DETECT: begin
                    if (det_done) begin
                        r_bin   <= det_bin;
                        r_ch    <= '0;
                        r_phase <= '0;
                        r_state <= c_READ;
                    end
                end
                c_READ: begin
                    if (r_phase == c_CAP_PHASE) begin
                        r_slot[r_ch] <= ram_q;
                        r_phase      <= '0;
                        if (r_ch == c_LAST_CH) begin
                            r_state <= c_DONE;
                        end else begin
                            r_ch <= r_ch + c_SW'(1);
                        end
                    end else begin
                        r_phase <= r_phase + 2'd1;
                    end
                end
                c_DONE: begin
                    res_bin   <= r_bin;
                    res_data  <= r_slot;
                    res_valid <= 1'b1;
                    frame_cnt <= frame_cnt + 16'd1;
                    r_state   <= c_IDLE;
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fft_frame_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fft_frame_ctrl
//  Description : Self-checking bench for fft_frame_ctrl. A two-cycle RAM model
//                holds random per-channel words; expected results are derived
//                from the frame rules (bin lookup per channel, frame counting,
//                sticky flags) rather than from the controller's structure.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fft_frame_ctrl;

    localparam int NCH = 4;
    localparam int AW  = 10;
    localparam int DW  = 28;
    localparam int TMO = 8192;

    logic                   clk;
    logic                   reset;
    logic                   frame_full;
    logic                   fft_start;
    logic                   fft_done;
    logic                   det_start;
    logic                   det_done;
    logic [AW-1:0]          det_bin;
    logic [AW-1:0]          det_addr;
    logic [AW-1:0]          ram_addr;
    logic [$clog2(NCH)-1:0] ram_sel;
    logic [DW-1:0]          ram_q;
    logic [AW-1:0]          res_bin;
    logic [NCH*DW-1:0]      res_data;
    logic                   res_valid;
    logic                   busy;
    logic                   overrun;
    logic                   timeout;
    logic [15:0]            frame_cnt;

    fft_frame_ctrl #(.NCH(NCH), .AW(AW), .DW(DW), .TMO(TMO)) dut (
        .clk        (clk),
        .reset      (reset),
        .frame_full (frame_full),
        .fft_start  (fft_start),
        .fft_done   (fft_done),
        .det_start  (det_start),
        .det_done   (det_done),
        .det_bin    (det_bin),
        .det_addr   (det_addr),
        .ram_addr   (ram_addr),
        .ram_sel    (ram_sel),
        .ram_q      (ram_q),
        .res_bin    (res_bin),
        .res_data   (res_data),
        .res_valid  (res_valid),
        .busy       (busy),
        .overrun    (overrun),
        .timeout    (timeout),
        .frame_cnt  (frame_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Channel RAM contents and a two-stage read pipeline.
    logic [DW-1:0] mem [NCH][1<<AW];
    logic [DW-1:0] q1, q2;
    always @(posedge clk) begin
        q1 <= mem[ram_sel][ram_addr];
        q2 <= q1;
    end
    assign ram_q = q2;

    // Pulse counters and back-to-back pulse detector.
    int n_fs = 0, n_ds = 0, n_valid = 0, n_consec = 0;
    logic p_fs = 1'b0, p_ds = 1'b0, p_rv = 1'b0;
    always @(negedge clk) begin
        if (fft_start) n_fs <= n_fs + 1;
        if (det_start) n_ds <= n_ds + 1;
        if (res_valid) n_valid <= n_valid + 1;
        if ((fft_start && p_fs) || (det_start && p_ds) || (res_valid && p_rv))
            n_consec <= n_consec + 1;
        p_fs <= fft_start;
        p_ds <= det_start;
        p_rv <= res_valid;
    end

    // Reference model state.
    int                total = 0;
    int                bad   = 0;
    int                exp_fs = 0, exp_ds = 0, exp_valid = 0;
    logic [15:0]       exp_cnt;
    logic              exp_ovr, exp_tmo;
    logic [AW-1:0]     exp_res_bin;
    logic [NCH*DW-1:0] exp_res_data;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic reset_model;
        exp_cnt      = '0;
        exp_ovr      = 1'b0;
        exp_tmo      = 1'b0;
        exp_res_bin  = '0;
        exp_res_data = '0;
    endtask

    task automatic do_reset;
        reset = 1'b1;
        tick;
        tick;
        reset = 1'b0;
        reset_model();
    endtask

    // Launch a frame and run it up to the first cycle of the bin read-out.
    task automatic start_to_read(input logic [AW-1:0] bin, input int fft_lat, input bit ovr_detect);
        int nerr;
        frame_full = 1'b1;
        tick;
        frame_full = 1'b0;
        exp_fs++;
        chk("fft_start", fft_start, 1);
        chk("busy_fft", busy, 1);
        // detector completion while the FFT runs must be ignored
        det_done = 1'b1;
        det_bin  = AW'($urandom);
        tick;
        det_done = 1'b0;
        chk("fft_start_one_cycle", fft_start, 0);
        chk("no_det_start_in_fft", det_start, 0);
        for (int i = 1; i < fft_lat; i++) tick;
        chk("ram_addr_hold_fft", ram_addr, exp_res_bin);
        fft_done = 1'b1;
        tick;
        fft_done = 1'b0;
        exp_ds++;
        chk("det_start", det_start, 1);
        chk("timeout_flag", timeout, exp_tmo);
        // FFT completion while detecting must be ignored
        fft_done = 1'b1;
        tick;
        fft_done = 1'b0;
        chk("det_start_one_cycle", det_start, 0);
        nerr = 0;
        for (int a = 0; a < (1 << AW); a++) begin
            det_addr = AW'(a);
            #1;
            if (ram_addr !== det_addr || ram_sel !== '0) nerr++;
        end
        chk("det_addr_tracking", nerr, 0);
        if (ovr_detect) begin
            frame_full = 1'b1;
            tick;
            frame_full = 1'b0;
            exp_ovr = 1'b1;
            chk("overrun_detect", overrun, 1);
            chk("busy_after_drop", busy, 1);
            chk("no_fft_start_on_drop", fft_start, 0);
        end
        det_bin  = bin;
        det_done = 1'b1;
        tick;
        det_done = 1'b0;
        det_bin  = AW'($urandom);
    endtask

    // Walk the read-out and check the published result.
    task automatic finish_read(input logic [AW-1:0] bin, input bit ovr_done);
        int nerr;
        nerr = 0;
        for (int i = 0; i < 3 * NCH; i++) begin
            if (ram_sel !== ($clog2(NCH))'(i / 3) || ram_addr !== bin ||
                res_valid !== 1'b0 || res_data !== exp_res_data) nerr++;
            tick;
        end
        chk("read_sequence", nerr, 0);
        chk("busy_done", busy, 1);
        chk("no_valid_before_done", res_valid, 0);
        if (ovr_done) begin
            frame_full = 1'b1;
            exp_ovr    = 1'b1;
        end
        tick;
        frame_full = 1'b0;
        for (int k = 0; k < NCH; k++) exp_res_data[k*DW +: DW] = mem[k][bin];
        exp_res_bin = bin;
        exp_cnt     = exp_cnt + 16'd1;
        exp_valid++;
        chk("res_valid", res_valid, 1);
        chk("res_bin", res_bin, exp_res_bin);
        chk("res_data", res_data, exp_res_data);
        chk("frame_cnt", frame_cnt, exp_cnt);
        chk("busy_idle", busy, 0);
        chk("overrun", overrun, exp_ovr);
        chk("fft_start_after_done", fft_start, 0);
        tick;
        chk("res_valid_one_cycle", res_valid, 0);
        chk("ram_addr_idle", ram_addr, exp_res_bin);
        chk("ram_sel_idle", ram_sel, 0);
    endtask

    task automatic run_frame(input logic [AW-1:0] bin, input int fft_lat);
        start_to_read(bin, fft_lat, 1'b0);
        finish_read(bin, 1'b0);
    endtask

    initial begin
        logic [AW-1:0] b;
        for (int k = 0; k < NCH; k++)
            for (int a = 0; a < (1 << AW); a++)
                mem[k][a] = DW'($urandom);
        reset      = 1'b1;
        frame_full = 1'b0;
        fft_done   = 1'b0;
        det_done   = 1'b0;
        det_bin    = '0;
        det_addr   = '0;
        reset_model();
        repeat (3) tick;
        chk("rst_busy", busy, 0);
        chk("rst_fft_start", fft_start, 0);
        chk("rst_det_start", det_start, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_flags", {overrun, timeout}, 0);
        chk("rst_frame_cnt", frame_cnt, 0);
        chk("rst_res", {res_bin, res_data}, 0);
        chk("rst_ram_port", {ram_addr, ram_sel}, 0);
        reset = 1'b0;
        tick;

        // stray completions in IDLE are ignored
        fft_done = 1'b1;
        det_done = 1'b1;
        tick;
        fft_done = 1'b0;
        det_done = 1'b0;
        chk("idle_ignore_busy", busy, 0);
        chk("idle_ignore_det_start", det_start, 0);

        // nominal frame
        for (int k = 0; k < NCH; k++) mem[k][10'h055] = DW'(32'h100_0000 + k);
        run_frame(10'h055, 100);

        // random frames
        for (int n = 0; n < 4; n++) begin
            b = AW'($urandom);
            run_frame(b, int'($urandom_range(1, 200)));
        end

        // completion on the last permitted FFT cycle wins over timeout
        b = AW'($urandom);
        run_frame(b, TMO - 1);
        chk("no_timeout_on_tie", timeout, 0);

        // FFT timeout
        frame_full = 1'b1;
        tick;
        frame_full = 1'b0;
        exp_fs++;
        for (int i = 1; i < TMO; i++) tick;
        chk("timeout_not_early", timeout, 0);
        chk("busy_before_timeout", busy, 1);
        tick;
        exp_tmo = 1'b1;
        chk("timeout_set", timeout, 1);
        chk("busy_after_timeout", busy, 0);
        chk("no_det_start_timeout", n_ds, exp_ds);
        chk("no_valid_timeout", n_valid, exp_valid);
        chk("ram_addr_after_timeout", ram_addr, exp_res_bin);
        b = AW'($urandom);
        run_frame(b, 7);
        chk("timeout_sticky", timeout, 1);

        // overrun during DETECT
        do_reset();
        chk("flags_cleared", {overrun, timeout}, 0);
        b = AW'($urandom);
        start_to_read(b, 30, 1'b1);
        finish_read(b, 1'b0);

        // frame offered in the DONE cycle is dropped
        do_reset();
        b = AW'($urandom);
        start_to_read(b, 12, 1'b0);
        finish_read(b, 1'b1);

        // reset after channel 1 captured aborts the frame
        b = AW'($urandom);
        start_to_read(b, 20, 1'b0);
        repeat (6) tick;
        reset = 1'b1;
        tick;
        reset_model();
        chk("abort_res_valid", res_valid, 0);
        chk("abort_res_data", res_data, 0);
        chk("abort_busy", busy, 0);
        chk("abort_frame_cnt", frame_cnt, 0);
        reset = 1'b0;
        repeat (20) tick;
        chk("abort_no_valid", n_valid, exp_valid);
        b = AW'($urandom);
        run_frame(b, 40);

        // frame counter wrap
        force dut.frame_cnt = 16'hFFFF;
        #1;
        release dut.frame_cnt;
        exp_cnt = 16'hFFFF;
        b = AW'($urandom);
        run_frame(b, 15);
        chk("frame_cnt_wrap", frame_cnt, 0);

        repeat (3) tick;
        chk("fft_start_count", n_fs, exp_fs);
        chk("det_start_count", n_ds, exp_ds);
        chk("res_valid_count", n_valid, exp_valid);
        chk("no_back_to_back_pulses", n_consec, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
